// File: rtl/ex_div_pkg.sv
// Shared encodings and constants for the EX-stage divider.
// The divider imports these so the state names and ready/start levels match the rest of the pipeline.
package ex_div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;

endpackage

// File: rtl/ex_div.sv
// Multi-cycle restoring divider for the EX stage: 32 quotient bits in 32 cycles,
// signed or unsigned, with abort on pipeline flush and a start/ready handshake.
module ex_div
  import ex_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state_reg;
  logic [5:0]  cnt_reg;
  logic [31:0] rem_reg;
  logic [31:0] quo_reg;
  logic [31:0] divisor_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign abs_a = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign abs_b = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // quo_reg starts as the dividend and is shifted out MSB-first while quotient bits shift in.
  assign shifted = {rem_reg, quo_reg[31]};
  assign trial   = shifted - {1'b0, divisor_reg};

  assign quo_fix = neg_q_reg ? (~quo_reg + 32'd1) : quo_reg;
  assign rem_fix = neg_r_reg ? (~rem_reg + 32'd1) : rem_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= DivFree;
      cnt_reg     <= 6'd0;
      rem_reg     <= ZeroWord;
      quo_reg     <= ZeroWord;
      divisor_reg <= ZeroWord;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      result_o    <= {ZeroWord, ZeroWord};
      ready_o     <= DivResultNotReady;
    end else begin
      case (state_reg)
        DivFree: begin
          result_o <= {ZeroWord, ZeroWord};
          ready_o  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            divisor_reg <= abs_b;
            quo_reg     <= abs_a;
            rem_reg     <= ZeroWord;
            neg_q_reg   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            neg_r_reg   <= signed_div_i & opdata1_i[31];
            cnt_reg     <= 6'd0;
            state_reg   <= (opdata2_i == ZeroWord) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          result_o  <= {ZeroWord, ZeroWord};
          ready_o   <= DivResultNotReady;
          state_reg <= DivEnd;
        end
        DivOn: begin
          if (annul_i) begin
            state_reg <= DivFree;
            cnt_reg   <= 6'd0;
            result_o  <= {ZeroWord, ZeroWord};
            ready_o   <= DivResultNotReady;
          end else if (cnt_reg == 6'd32) begin
            result_o  <= {rem_fix, quo_fix};
            ready_o   <= DivResultReady;
            cnt_reg   <= 6'd0;
            state_reg <= DivEnd;
          end else begin
            // Negative trial result means the divisor did not fit: keep the shifted remainder.
            rem_reg <= trial[32] ? shifted[31:0] : trial[31:0];
            quo_reg <= {quo_reg[30:0], ~trial[32]};
            cnt_reg <= cnt_reg + 6'd1;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            state_reg <= DivFree;
            result_o  <= {ZeroWord, ZeroWord};
            ready_o   <= DivResultNotReady;
          end else begin
            ready_o <= DivResultReady;
          end
        end
        default: state_reg <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: driver pushes model results, a negedge monitor checks
// result value and exact ready cycle whenever ready_o rises.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  ex_div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          at;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference: plain 64-bit integer division, truncating toward zero.
  function automatic logic [63:0] model(bit sgn, logic [31:0] a, logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    if (ready_o === 1'b1 && prev_ready !== 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ready at cycle %0d: result_o=%h, expected no ready", cyc, result_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.tag, result_o, e.res);
        check({e.tag, "_cycle"}, 64'(cyc), 64'(e.at));
      end
    end
    prev_ready <= ready_o;
  end

  task automatic do_div(bit sgn, logic [31:0] a, logic [31:0] b, bit annul_flag, string tag);
    exp_t e;
    bit   got;
    logic [63:0] r;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    e.res = model(sgn, a, b);
    e.at  = cyc + 1 + ((b == 32'd0) ? 2 : 33);
    e.tag = tag;
    sb.push_back(e);
    r   = e.res;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ready_o === 1'b1) got = 1'b1;
      else begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
        annul_i      = annul_flag;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: ready_o=0, expected 1", tag);
    end
    annul_i = annul_flag;
    @(negedge clk);
    check({tag, "_hold"}, {ready_o, result_o}, {1'b1, r});
    start_i = 1'b0;
    annul_i = 1'b0;
    @(negedge clk);
    check({tag, "_drop"}, {ready_o, result_o}, 65'd0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_state", {ready_o, result_o}, 65'd0);
    rst = 1'b0;

    do_div(0, 32'd100,        32'd7,        0, "u_100_7");
    check("u_100_7_const", model(0, 32'd100, 32'd7), 64'h00000002_0000000E);
    do_div(1, 32'hFFFFFFF9,   32'h00000002, 0, "s_m7_2");
    do_div(1, 32'h00000007,   32'hFFFFFFFE, 0, "s_7_m2");
    do_div(0, 32'h00001234,   32'd0,        0, "u_div0");
    do_div(1, 32'h80000005,   32'd0,        1, "s_div0_annul");
    do_div(1, 32'h80000000,   32'hFFFFFFFF, 0, "s_min_m1");
    do_div(0, 32'hFFFFFFFF,   32'd1,        0, "u_max_1");
    do_div(0, 32'd0,          32'd5,        0, "u_0_5");
    do_div(0, 32'h80000000,   32'hFFFFFFFF, 0, "u_big_big");

    // Flush in the middle of a division: no ready, then a clean new request.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    check("annul_free", {ready_o, result_o}, 65'd0);
    repeat (40) @(negedge clk);
    do_div(0, 32'd9, 32'd3, 0, "u_9_3_after_annul");

    // Reset in the middle of a division.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (21) @(negedge clk);
    rst = 1'b1; annul_i = 1'b1;
    @(negedge clk);
    rst = 1'b0; annul_i = 1'b0; start_i = 1'b0;
    check("rst_mid_on", {ready_o, result_o}, 65'd0);
    repeat (40) @(negedge clk);
    do_div(1, 32'h80000000, 32'hFFFFFFFF, 0, "s_min_m1_after_rst");

    for (int k = 0; k < 40; k++) begin
      logic [31:0] a, b;
      bit s;
      int sel;
      a   = $urandom;
      b   = $urandom;
      s   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) b = 32'($urandom_range(1, 15));
      else if (sel == 2) b = 32'hFFFFFFFF;
      do_div(s, a, b, 0, $sformatf("rand%0d", k));
    end

    repeat (5) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
REQ-004 SHALL have port opdata1_i  input  32  dividend; sampled with start_i.
REQ-005 SHALL have port opdata2_i  input  32  divisor; sampled with start_i.
REQ-006 SHALL have port start_i  input  1  request from EX stage; level, held high until ready_o seen.
REQ-007 SHALL have port annul_i  input  1  abort request (pipeline flush).
REQ-008 SHALL have port result_o  output  64  {remainder[63:32], quotient[31:0]}.
REQ-009 SHALL have port ready_o  output  1  result_o valid.

Function
REQ-010 SHALL implement a four-state FSM: FREE, BYZERO, ON, END.
REQ-011 SHALL, in FREE with start_i=1 and annul_i=0, latch operands and go to BYZERO if opdata2_i==0, else ON with iteration counter cleared; otherwise stay in FREE.
REQ-012 SHALL, in signed mode, operate on absolute values (two's-complement negate of negative operands) and record sign of quotient (dividend sign XOR divisor sign) and of remainder (dividend sign).
REQ-013 SHALL perform restoring division: one quotient bit per ON cycle via 33-bit trial subtraction of divisor from the shifted partial remainder; 6-bit counter 0..32.
REQ-014 SHALL, in ON with counter==32, apply sign correction, load result_o, set ready_o=1, go to END.
REQ-015 SHALL give fixed latency: accept edge t, ready_o=1 after edge t+33; independent of operand values.
REQ-016 SHALL, in BYZERO, go to END on next edge with result_o=0, ready_o=1 (ready after edge t+2).
REQ-017 SHALL, in END, hold result_o and ready_o=1 while start_i=1; when start_i=0, go to FREE with ready_o=0, result_o=0.
REQ-018 SHALL, when annul_i=1 in ON, go to FREE on next edge with ready_o=0, result_o=0; annul_i SHALL have no effect in END or BYZERO.
REQ-019 SHALL ignore operand changes after acceptance; start_i deassert in ON (without annul_i) SHALL not abort.
REQ-020 SHALL for signed 0x80000000 / 0xFFFFFFFF give quotient 0x80000000, remainder 0 (wrap, no trap).
REQ-021 SHALL keep ready_o=0 in FREE, BYZERO, ON.

Reset
REQ-022 SHALL on rst=1 at a rising edge enter FREE, clear counter, result_o=0, ready_o=0, regardless of state (including mid-ON).
REQ-023 SHALL give rst priority over annul_i and start_i.

Structure
REQ-024 SHALL take state encodings (DivFree, DivByZero, DivOn, DivEnd), DivResultReady/NotReady, DivStart/Stop and ZeroWord from the shared defines file.
REQ-025 SHALL be a single module; no sub-module, subtraction and negation inline.
REQ-026 SHALL be purely synchronous; outputs registered.

Verification
REQ-027 Unsigned 100/7, start held -> ready_o after edge t+33, result_o=0x00000002_0000000E.
REQ-028 Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD; signed 7/-2 -> 0x00000001_FFFFFFFD.
REQ-029 Divisor 0 (any dividend) -> ready_o after edge t+2, result_o=0; start_i dropped -> ready_o=0 next edge.
REQ-030 Start 0xFFFFFFFF/3 unsigned, annul_i at cycle 10 -> FREE, ready_o never rises; new 9/3 request then yields 0x00000000_00000003.
REQ-031 rst pulse at cycle 20 of ON -> ready_o=0, result_o=0, FREE; signed 0x80000000/0xFFFFFFFF afterwards -> 0x00000000_80000000.
